// File: rtl/alarm_clock_pkg.sv
// Shared types and constants for the alarm clock setting controller.
// Holds the FSM state enum, the edit_mode encoding and the field widths.
package alarm_clock_pkg;

    localparam int HOUR_W = 4;
    localparam int MIN_W  = 6;

    localparam int DEF_HOUR_MIN = 1;
    localparam int DEF_HOUR_MAX = 12;
    localparam int DEF_MIN_MAX  = 59;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EDIT_TIME,
        ST_EDIT_ALARM,
        ST_COMMIT_TIME,
        ST_COMMIT_ALARM
    } state_t;

    localparam logic [1:0] MODE_IDLE   = 2'd0;
    localparam logic [1:0] MODE_TIME   = 2'd1;
    localparam logic [1:0] MODE_ALARM  = 2'd2;
    localparam logic [1:0] MODE_COMMIT = 2'd3;

    // Bit positions of the buttons inside the controller's button vector.
    localparam int BTN_HOUR   = 0;
    localparam int BTN_MIN    = 1;
    localparam int BTN_MODE   = 2;
    localparam int BTN_OK     = 3;
    localparam int BTN_CANCEL = 4;
    localparam int BTN_COUNT  = 5;

    // Increment with wrap; equality against the top value keeps it cheap.
    function automatic logic [MIN_W-1:0] wrap_inc(
        input logic [MIN_W-1:0] value,
        input logic [MIN_W-1:0] lo,
        input logic [MIN_W-1:0] hi
    );
        return (value == hi) ? lo : value + MIN_W'(1);
    endfunction

endpackage

// File: rtl/btn_press_repeat.sv
// Rising-edge detector for a debounced button, with optional hold-to-repeat.
// pulse fires on the press and, when enabled, at DELAY then every RATE cycles of hold.
module btn_press_repeat #(
    parameter bit REPEAT_EN    = 1'b1,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic btn_reg;
    logic press;

    assign press = btn & ~btn_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            btn_reg <= 1'b0;
        end else begin
            btn_reg <= btn;
        end
    end

    generate
        if (REPEAT_EN) begin : g_repeat
            localparam int HW = $clog2(REPEAT_DELAY + 1);
            localparam int RW = (REPEAT_RATE > 1) ? $clog2(REPEAT_RATE) : 1;

            logic [HW-1:0] hold_reg;
            logic [RW-1:0] rate_reg;
            logic          repeat_hit;

            // hold_reg saturates at the delay; rate_reg then paces later repeats.
            assign repeat_hit = btn && !press && (hold_reg == HW'(REPEAT_DELAY))
                                && (rate_reg == '0);

            always_ff @(posedge clock) begin
                if (reset || !btn) begin
                    hold_reg <= '0;
                    rate_reg <= '0;
                end else if (press) begin
                    hold_reg <= HW'(1);
                    rate_reg <= '0;
                end else if (hold_reg != HW'(REPEAT_DELAY)) begin
                    hold_reg <= hold_reg + HW'(1);
                end else if (rate_reg == RW'(REPEAT_RATE - 1)) begin
                    rate_reg <= '0;
                end else begin
                    rate_reg <= rate_reg + RW'(1);
                end
            end

            assign pulse = press | repeat_hit;
        end else begin : g_edge_only
            assign pulse = press;
        end
    endgenerate

endmodule

// File: rtl/alarm_set_controller.sv
// Front-panel setting controller: edits time/alarm fields from buttons and
// issues one-cycle set_time / set_alarm commit strobes to the clock core.
module alarm_set_controller
    import alarm_clock_pkg::*;
#(
    parameter int HOUR_MIN     = DEF_HOUR_MIN,
    parameter int HOUR_MAX     = DEF_HOUR_MAX,
    parameter int MIN_MAX      = DEF_MIN_MAX,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              btn_mode,
    input  logic              btn_hour,
    input  logic              btn_min,
    input  logic              btn_ok,
    input  logic              btn_cancel,
    output logic              set_time,
    output logic              set_alarm,
    output logic [HOUR_W-1:0] hours,
    output logic [MIN_W-1:0]  minutes,
    output logic [HOUR_W-1:0] alarm_hours,
    output logic [MIN_W-1:0]  alarm_minutes,
    output logic [1:0]        edit_mode
);

    logic [BTN_COUNT-1:0] btn_vec;
    logic [BTN_COUNT-1:0] fire;

    assign btn_vec = {btn_cancel, btn_ok, btn_mode, btn_min, btn_hour};

    genvar gi;
    generate
        for (gi = 0; gi < BTN_COUNT; gi++) begin : g_btn
            btn_press_repeat #(
                .REPEAT_EN   ((gi == BTN_HOUR) || (gi == BTN_MIN)),
                .REPEAT_DELAY(REPEAT_DELAY),
                .REPEAT_RATE (REPEAT_RATE)
            ) u_btn (
                .clock(clock),
                .reset(reset),
                .btn  (btn_vec[gi]),
                .pulse(fire[gi])
            );
        end
    endgenerate

    state_t state_reg;
    state_t state_next;

    logic [HOUR_W-1:0] hours_reg, alarm_hours_reg, bak_hours_reg;
    logic [MIN_W-1:0]  minutes_reg, alarm_minutes_reg, bak_minutes_reg;
    logic [HOUR_W-1:0] hours_inc, alarm_hours_inc;
    logic [MIN_W-1:0]  minutes_inc, alarm_minutes_inc;

    assign hours_inc         = HOUR_W'(wrap_inc(MIN_W'(hours_reg), MIN_W'(HOUR_MIN), MIN_W'(HOUR_MAX)));
    assign alarm_hours_inc   = HOUR_W'(wrap_inc(MIN_W'(alarm_hours_reg), MIN_W'(HOUR_MIN), MIN_W'(HOUR_MAX)));
    assign minutes_inc       = wrap_inc(minutes_reg, '0, MIN_W'(MIN_MAX));
    assign alarm_minutes_inc = wrap_inc(alarm_minutes_reg, '0, MIN_W'(MIN_MAX));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Priority: cancel > ok > mode > hour/min.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:       if (fire[BTN_MODE]) state_next = ST_EDIT_TIME;
            ST_EDIT_TIME: begin
                if (fire[BTN_CANCEL])    state_next = ST_IDLE;
                else if (fire[BTN_OK])   state_next = ST_COMMIT_TIME;
                else if (fire[BTN_MODE]) state_next = ST_EDIT_ALARM;
            end
            ST_EDIT_ALARM: begin
                if (fire[BTN_CANCEL])    state_next = ST_IDLE;
                else if (fire[BTN_OK])   state_next = ST_COMMIT_ALARM;
                else if (fire[BTN_MODE]) state_next = ST_IDLE;
            end
            default:       state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        set_time  = 1'b0;
        set_alarm = 1'b0;
        edit_mode = MODE_IDLE;
        case (state_reg)
            ST_EDIT_TIME:    edit_mode = MODE_TIME;
            ST_EDIT_ALARM:   edit_mode = MODE_ALARM;
            ST_COMMIT_TIME:  begin edit_mode = MODE_COMMIT; set_time  = 1'b1; end
            ST_COMMIT_ALARM: begin edit_mode = MODE_COMMIT; set_alarm = 1'b1; end
            default:         edit_mode = MODE_IDLE;
        endcase
    end

    // Fields only move in edit states when no higher-priority button fired.
    always_ff @(posedge clock) begin
        if (reset) begin
            hours_reg         <= HOUR_W'(HOUR_MIN);
            minutes_reg       <= '0;
            alarm_hours_reg   <= HOUR_W'(HOUR_MIN);
            alarm_minutes_reg <= '0;
            bak_hours_reg     <= '0;
            bak_minutes_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (fire[BTN_MODE]) begin
                        bak_hours_reg   <= hours_reg;
                        bak_minutes_reg <= minutes_reg;
                    end
                end
                ST_EDIT_TIME: begin
                    if (fire[BTN_CANCEL]) begin
                        hours_reg   <= bak_hours_reg;
                        minutes_reg <= bak_minutes_reg;
                    end else if (!fire[BTN_OK] && fire[BTN_MODE]) begin
                        hours_reg       <= bak_hours_reg;
                        minutes_reg     <= bak_minutes_reg;
                        bak_hours_reg   <= alarm_hours_reg;
                        bak_minutes_reg <= alarm_minutes_reg;
                    end else if (!fire[BTN_OK]) begin
                        if (fire[BTN_HOUR]) hours_reg   <= hours_inc;
                        if (fire[BTN_MIN])  minutes_reg <= minutes_inc;
                    end
                end
                ST_EDIT_ALARM: begin
                    if (fire[BTN_CANCEL] || (!fire[BTN_OK] && fire[BTN_MODE])) begin
                        alarm_hours_reg   <= bak_hours_reg;
                        alarm_minutes_reg <= bak_minutes_reg;
                    end else if (!fire[BTN_OK]) begin
                        if (fire[BTN_HOUR]) alarm_hours_reg   <= alarm_hours_inc;
                        if (fire[BTN_MIN])  alarm_minutes_reg <= alarm_minutes_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hours         = hours_reg;
    assign minutes       = minutes_reg;
    assign alarm_hours   = alarm_hours_reg;
    assign alarm_minutes = alarm_minutes_reg;

endmodule

// File: tb/tb_alarm_set_controller.sv
// Bench for alarm_set_controller: directed scenarios plus random button traffic,
// compared cycle by cycle against a behavioural model of the setting rules.
module tb_alarm_set_controller;

    localparam int D = 50;
    localparam int R = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0, btn_hour = 1'b0, btn_min = 1'b0, btn_ok = 1'b0, btn_cancel = 1'b0;
    logic       set_time, set_alarm;
    logic [3:0] hours, alarm_hours;
    logic [5:0] minutes, alarm_minutes;
    logic [1:0] edit_mode;

    int n_cmp = 0;
    int n_bad = 0;

    alarm_set_controller #(.REPEAT_DELAY(D), .REPEAT_RATE(R)) dut (
        .clock(clock), .reset(reset),
        .btn_mode(btn_mode), .btn_hour(btn_hour), .btn_min(btn_min),
        .btn_ok(btn_ok), .btn_cancel(btn_cancel),
        .set_time(set_time), .set_alarm(set_alarm),
        .hours(hours), .minutes(minutes),
        .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes),
        .edit_mode(edit_mode)
    );

    always #5 clock = ~clock;

    // Model: mode 0 idle, 1 edit time, 2 edit alarm, 3 commit time, 4 commit alarm.
    int m_mode, m_h, m_m, m_ah, m_am, m_bh, m_bm;
    int held [5];
    bit prev [5];

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int inc_wrap(input int v, input int lo, input int hi);
        return (v == hi) ? lo : v + 1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_h = 1; m_m = 0; m_ah = 1; m_am = 0; m_bh = 0; m_bm = 0;
        for (int i = 0; i < 5; i++) begin
            held[i] = -1;
            prev[i] = 1'b0;
        end
    endtask

    // Bit order: 0 hour, 1 min, 2 mode, 3 ok, 4 cancel.
    task automatic model_step(input logic [4:0] b);
        bit f [5];
        for (int i = 0; i < 5; i++) begin
            f[i] = 1'b0;
            if (b[i]) begin
                held[i] = prev[i] ? held[i] + 1 : 0;
                f[i] = (held[i] == 0) ||
                       (i < 2 && held[i] >= D && ((held[i] - D) % R) == 0);
            end else begin
                held[i] = -1;
            end
            prev[i] = b[i];
        end
        case (m_mode)
            0: if (f[2]) begin m_bh = m_h; m_bm = m_m; m_mode = 1; end
            1: begin
                if (f[4]) begin m_h = m_bh; m_m = m_bm; m_mode = 0; end
                else if (f[3]) m_mode = 3;
                else if (f[2]) begin
                    m_h = m_bh; m_m = m_bm; m_bh = m_ah; m_bm = m_am; m_mode = 2;
                end else begin
                    if (f[0]) m_h = inc_wrap(m_h, 1, 12);
                    if (f[1]) m_m = inc_wrap(m_m, 0, 59);
                end
            end
            2: begin
                if (f[4]) begin m_ah = m_bh; m_am = m_bm; m_mode = 0; end
                else if (f[3]) m_mode = 4;
                else if (f[2]) begin m_ah = m_bh; m_am = m_bm; m_mode = 0; end
                else begin
                    if (f[0]) m_ah = inc_wrap(m_ah, 1, 12);
                    if (f[1]) m_am = inc_wrap(m_am, 0, 59);
                end
            end
            default: m_mode = 0;
        endcase
    endtask

    task automatic compare_all();
        check("set_time", int'(set_time), (m_mode == 3) ? 1 : 0);
        check("set_alarm", int'(set_alarm), (m_mode == 4) ? 1 : 0);
        check("edit_mode", int'(edit_mode), (m_mode >= 3) ? 3 : m_mode);
        check("hours", int'(hours), m_h);
        check("minutes", int'(minutes), m_m);
        check("alarm_hours", int'(alarm_hours), m_ah);
        check("alarm_minutes", int'(alarm_minutes), m_am);
    endtask

    task automatic step(input logic [4:0] b, input bit rst);
        btn_hour = b[0]; btn_min = b[1]; btn_mode = b[2]; btn_ok = b[3]; btn_cancel = b[4];
        reset = rst;
        @(posedge clock);
        if (rst) model_reset();
        else model_step(b);
        #1;
        compare_all();
        $display("cyc rst=%0b btn=%05b -> mode=%0d st=%0b sa=%0b t=%0d:%0d a=%0d:%0d",
                 rst, b, edit_mode, set_time, set_alarm, hours, minutes, alarm_hours, alarm_minutes);
    endtask

    task automatic tap(input int idx, input int times);
        logic [4:0] b;
        for (int t = 0; t < times; t++) begin
            b = '0;
            b[idx] = 1'b1;
            step(b, 1'b0);
            step(5'b0, 1'b0);
        end
    endtask

    int dur [5];
    logic [4:0] rb;

    initial begin
        model_reset();
        step(5'b0, 1'b1);
        step(5'b0, 1'b1);
        check("rst_hours", int'(hours), 1);
        check("rst_minutes", int'(minutes), 0);
        check("rst_edit_mode", int'(edit_mode), 0);
        step(5'b0, 1'b0);
        check("rst_no_strobe", int'(set_time | set_alarm), 0);

        // Set time to 6:26.
        tap(2, 1); tap(0, 5); tap(1, 26);
        step(5'b01000, 1'b0);
        check("t1_set_time", int'(set_time), 1);
        check("t1_hours", int'(hours), 6);
        check("t1_minutes", int'(minutes), 26);
        check("t1_set_alarm", int'(set_alarm), 0);
        step(5'b0, 1'b0);
        check("t1_idle", int'(edit_mode), 0);
        check("t1_strobe_len", int'(set_time), 0);

        // Set alarm to 9:46.
        tap(2, 2); tap(0, 8); tap(1, 46);
        step(5'b01000, 1'b0);
        check("t2_set_alarm", int'(set_alarm), 1);
        check("t2_set_time", int'(set_time), 0);
        check("t2_alarm_hours", int'(alarm_hours), 9);
        check("t2_alarm_minutes", int'(alarm_minutes), 46);
        check("t2_hours_kept", int'(hours), 6);
        check("t2_minutes_kept", int'(minutes), 26);
        step(5'b0, 1'b0);

        // Wrap both fields in the same cycle, then cancel.
        tap(2, 1); tap(0, 6); tap(1, 33);
        check("t3_pre_hours", int'(hours), 12);
        check("t3_pre_minutes", int'(minutes), 59);
        step(5'b00011, 1'b0);
        check("t3_wrap_hours", int'(hours), 1);
        check("t3_wrap_minutes", int'(minutes), 0);
        step(5'b0, 1'b0);
        tap(4, 1);
        check("t3_restore_hours", int'(hours), 6);

        // Cancel restores; ok+cancel together gives no strobe.
        tap(2, 1); tap(1, 10);
        step(5'b10000, 1'b0);
        check("t4_restore_minutes", int'(minutes), 26);
        check("t4_idle", int'(edit_mode), 0);
        step(5'b0, 1'b0);
        check("t4_no_strobe", int'(set_time), 0);
        tap(2, 1);
        step(5'b11000, 1'b0);
        check("t4_cancel_wins", int'(edit_mode), 0);
        step(5'b0, 1'b0);
        check("t4_no_strobe2", int'(set_time), 0);

        // Auto-repeat from minutes=0: press plus repeats at 50, 60, 70.
        step(5'b0, 1'b1);
        tap(2, 1);
        for (int k = 0; k < 80; k++) step(5'b00010, 1'b0);
        step(5'b0, 1'b0);
        check("t5_repeat_minutes", int'(minutes), 4);
        tap(4, 1);

        // Reset mid-edit and in the commit cycle.
        tap(2, 1); tap(0, 3); tap(1, 7);
        step(5'b0, 1'b1);
        check("t6_rst_hours", int'(hours), 1);
        check("t6_rst_mode", int'(edit_mode), 0);
        tap(2, 1); tap(0, 2);
        step(5'b01000, 1'b0);
        check("t6_commit_seen", int'(set_time), 1);
        step(5'b0, 1'b1);
        check("t6_no_set_time", int'(set_time), 0);
        check("t6_rst_hours2", int'(hours), 1);
        step(5'b0, 1'b0);
        check("t6_no_set_time2", int'(set_time), 0);

        // Random traffic with occasional long holds and rare resets.
        for (int i = 0; i < 5; i++) dur[i] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 5; i++) begin
                if (dur[i] > 0) begin
                    rb[i] = 1'b1;
                    dur[i]--;
                end else begin
                    rb[i] = 1'b0;
                    if (i < 2 && $urandom_range(0, 3) == 0)
                        dur[i] = ($urandom_range(0, 5) == 0) ? $urandom_range(40, 90) : $urandom_range(1, 3);
                    else if (i == 2 && $urandom_range(0, 11) == 0) dur[i] = 1;
                    else if (i == 3 && $urandom_range(0, 24) == 0) dur[i] = $urandom_range(1, 2);
                    else if (i == 4 && $urandom_range(0, 39) == 0) dur[i] = 1;
                end
            end
            step(rb, $urandom_range(0, 399) == 0);
            check("excl_strobes", int'(set_time & set_alarm), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
